// File: rtl/grover_sequencer.sv
// Three-qubit Grover search sequencer over eight signed Q1.6 amplitudes.
// One search: LOAD the uniform state, then num_iter rounds of
// ORACLE (flip the marked amplitude) -> MEAN -> DIFFUSE (invert about mean).
//
// Handshake: start is a request sampled only while IDLE. The block accepts it
// on that clock edge and latches target_search and num_iter. busy is high from
// LOAD through the last DIFFUSE. done is high for the single DONE cycle, after
// which the block returns to IDLE and may take a new start.
module grover_sequencer #(
  parameter int INIT_AMP = 23,
  parameter int ITER_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        target_search,
  input  logic [ITER_W-1:0] num_iter,
  output logic              busy,
  output logic              done,
  output logic signed [7:0] amp0,
  output logic signed [7:0] amp1,
  output logic signed [7:0] amp2,
  output logic signed [7:0] amp3,
  output logic signed [7:0] amp4,
  output logic signed [7:0] amp5,
  output logic signed [7:0] amp6,
  output logic signed [7:0] amp7
);

  localparam logic signed [7:0] INIT_VAL = 8'(INIT_AMP);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ORACLE  = 3'd2,
    S_MEAN    = 3'd3,
    S_DIFFUSE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [7:0]  amp_q [8];
  logic signed [7:0]  mean;
  logic [ITER_W-1:0]  iter_cnt;
  logic [ITER_W-1:0]  iter_inc;
  logic [ITER_W-1:0]  num_iter_q;
  logic [2:0]         tgt_q;

  logic signed [10:0] sum;
  logic signed [7:0]  neg_amp;
  logic signed [9:0]  diff     [8];
  logic signed [7:0]  diff_sat [8];

  assign amp0 = amp_q[0];
  assign amp1 = amp_q[1];
  assign amp2 = amp_q[2];
  assign amp3 = amp_q[3];
  assign amp4 = amp_q[4];
  assign amp5 = amp_q[5];
  assign amp6 = amp_q[6];
  assign amp7 = amp_q[7];

  assign iter_inc = iter_cnt + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        busy       = 1'b1;
        state_next = (num_iter_q == '0) ? S_DONE : S_ORACLE;
      end
      S_ORACLE: begin
        busy       = 1'b1;
        state_next = S_MEAN;
      end
      S_MEAN: begin
        busy       = 1'b1;
        state_next = S_DIFFUSE;
      end
      S_DIFFUSE: begin
        busy       = 1'b1;
        state_next = (iter_inc == num_iter_q) ? S_DONE : S_ORACLE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Arithmetic: 11-bit sum for the mean, saturating oracle negation, and
  // saturating 10-bit inversion about the mean.
  always_comb begin
    sum = '0;
    for (int k = 0; k < 8; k++) begin
      sum = sum + {{3{amp_q[k][7]}}, amp_q[k]};
    end
    neg_amp = (amp_q[tgt_q] == 8'sh80) ? 8'sd127 : -amp_q[tgt_q];
    for (int k = 0; k < 8; k++) begin
      diff[k] = {mean[7], mean, 1'b0} - {{2{amp_q[k][7]}}, amp_q[k]};
      if (diff[k] > 10'sd127) begin
        diff_sat[k] = 8'sd127;
      end else if (diff[k] < -10'sd128) begin
        diff_sat[k] = -8'sd128;
      end else begin
        diff_sat[k] = diff[k][7:0];
      end
    end
  end

  // Datapath registers, updated according to the current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) amp_q[k] <= '0;
      mean       <= '0;
      iter_cnt   <= '0;
      num_iter_q <= '0;
      tgt_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            tgt_q      <= target_search;
            num_iter_q <= num_iter;
          end
        end
        S_LOAD: begin
          for (int k = 0; k < 8; k++) amp_q[k] <= INIT_VAL;
          iter_cnt <= '0;
        end
        S_ORACLE: begin
          amp_q[tgt_q] <= neg_amp;
        end
        S_MEAN: begin
          mean <= sum[10:3];
        end
        S_DIFFUSE: begin
          for (int k = 0; k < 8; k++) amp_q[k] <= diff_sat[k];
          iter_cnt <= iter_inc;
        end
        default: ;
      endcase
    end
  end

endmodule
